snake_dir_ctrl: RTL and testbench

- Converts the four debounced button levels into the snake's movement direction, one turn committed per game step.
- Sits between the debounce instances and snake_model.
- Detects button rising edges and rejects null or 180° turns.
- Buffers up to QUEUE_DEPTH pending turns so fast double-taps between steps are not lost.

---
 rtl/snake_pkg.sv | 17 +
 rtl/dir_fifo.sv | 76 +++++++
 rtl/snake_dir_ctrl.sv | 100 ++++++++++
 tb/tb_snake_dir_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Direction encoding and helpers shared by the snake game blocks.
// No logic of its own; imported by snake_dir_ctrl, dir_fifo and snake_model.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    // Opposite directions share the axis bit and differ in the sense bit.
    function automatic logic is_opposite(input dir_t a, input dir_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small circular FIFO of pending turns, with head and tail peek outputs.
// Latency: push visible in count/tail on the next edge; head is read combinationally.
// Backpressure: push is honoured when not full or when a pop happens in the same cycle.
module dir_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  dir_t             push_dat,
    output dir_t             head_dat,
    output dir_t             tail_dat,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    dir_t             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic             pop_ok;
    logic             push_ok;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign tail_ptr = (wr_ptr == '0) ? LAST : wr_ptr - PTR_W'(1);
    assign head_dat = mem[rd_ptr];
    assign tail_dat = mem[tail_ptr];

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // The count register alone decides full/empty, so pointers may alias when full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop_ok) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            if (push_ok) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Turns debounced button levels into the committed snake direction, one turn per step.
// Latency: press queued one cycle after the rising edge; dir updates one cycle after step.
// Backpressure: presses arriving with a full queue and no step are dropped and counted.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int   QUEUE_DEPTH = 2,
    parameter dir_t INIT_DIR    = DIR_RIGHT,
    parameter int   DROP_W      = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             left,
    input  logic                             right,
    input  logic                             up,
    input  logic                             down,
    input  logic                             step,
    input  logic                             game_over,
    output dir_t                             dir,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
    output logic [DROP_W-1:0]                drop_cnt
);

    logic [3:0] btn;
    logic [3:0] prev_btn;
    logic [3:0] press;
    logic       cand_vld;
    dir_t       cand;
    dir_t       ref_dir;
    dir_t       head_dat;
    dir_t       tail_dat;
    logic       full;
    logic       empty;
    logic       turn_ok;
    logic       pop_req;
    logic       push_req;
    logic       drop;

    assign btn   = {up, down, left, right};
    assign press = btn & ~prev_btn;

    // History starts high so a button held through reset needs a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_btn <= 4'b1111;
        end else begin
            prev_btn <= btn;
        end
    end

    always_comb begin
        cand_vld = |press;
        cand     = DIR_RIGHT;
        if (press[3]) begin
            cand = DIR_UP;
        end else if (press[2]) begin
            cand = DIR_DOWN;
        end else if (press[1]) begin
            cand = DIR_LEFT;
        end
    end

    // Filter against the last turn the snake will take, not the one it is taking now.
    assign ref_dir  = empty ? dir : tail_dat;
    assign turn_ok  = cand_vld && !game_over && (cand != ref_dir) && !is_opposite(cand, ref_dir);
    assign pop_req  = step && !empty && !game_over;
    assign push_req = turn_ok && (!full || pop_req);
    assign drop     = turn_ok && full && !pop_req;

    dir_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (game_over),
        .push     (push_req),
        .pop      (pop_req),
        .push_dat (cand),
        .head_dat (head_dat),
        .tail_dat (tail_dat),
        .count    (queue_count),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir      <= INIT_DIR;
            drop_cnt <= '0;
        end else begin
            if (pop_req) begin
                dir <= head_dat;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed vector table, hand sequences and a random run against a queue model.
module tb_snake_dir_ctrl;

    localparam int QD = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
    logic       step = 1'b0, game_over = 1'b0;
    logic [1:0] dir;
    logic [1:0] queue_count;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    snake_dir_ctrl #(.QUEUE_DEPTH(QD), .INIT_DIR(2'b11), .DROP_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .left        (left),
        .right       (right),
        .up          (up),
        .down        (down),
        .step        (step),
        .game_over   (game_over),
        .dir         (dir),
        .queue_count (queue_count),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: pending turns as a plain queue of directions.
    logic [1:0] q[$];
    logic [1:0] m_dir;
    int         m_drop;
    logic [3:0] m_prev;
    logic [1:0] opp_of [4] = '{2'b01, 2'b00, 2'b11, 2'b10};

    typedef struct {
        logic [5:0] in;   // {up, down, left, right, step, game_over}
        logic [1:0] dir;
        int         cnt;
        int         drp;
    } vec_t;

    vec_t tbl [31];

    function automatic vec_t mk(input logic [5:0] in, input logic [1:0] d, input int c, input int dr);
        vec_t v;
        v.in = in; v.dir = d; v.cnt = c; v.drp = dr;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] in);
        {up, down, left, right, step, game_over} = in;
    endtask

    task automatic model_reset();
        q.delete();
        m_dir  = 2'b11;
        m_drop = 0;
        m_prev = 4'b1111;
    endtask

    task automatic model_step();
        logic [3:0] lv;
        logic [1:0] cand;
        logic [1:0] rf;
        bit         has;
        bit         popped;
        lv   = {up, down, left, right};
        has  = 0;
        cand = 2'b00;
        if (game_over) begin
            q.delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!has && lv[3-k] && !m_prev[3-k]) begin
                    has  = 1;
                    cand = 2'(k);
                end
            end
            rf     = (q.size() > 0) ? q[$] : m_dir;
            popped = step && (q.size() > 0);
            if (popped) m_dir = q.pop_front();
            if (has && cand != rf && cand != opp_of[rf]) begin
                if (q.size() < QD) q.push_back(cand);
                else if (m_drop < 255) m_drop++;
            end
        end
        m_prev = lv;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".dir"}, int'(dir), int'(m_dir));
        check({tag, ".cnt"}, int'(queue_count), q.size());
        check({tag, ".drop"}, int'(drop_cnt), m_drop);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.dir", int'(dir), 3);
        check("rst.cnt", int'(queue_count), 0);
        check("rst.drop", int'(drop_cnt), 0);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = mk(6'b000000, 2'b11, 0, 0);
        tbl[1]  = mk(6'b001000, 2'b11, 0, 0);
        tbl[2]  = mk(6'b000010, 2'b11, 0, 0);
        tbl[3]  = mk(6'b100000, 2'b11, 1, 0);
        tbl[4]  = mk(6'b000010, 2'b00, 0, 0);
        tbl[5]  = mk(6'b000100, 2'b00, 1, 0);
        tbl[6]  = mk(6'b000010, 2'b11, 0, 0);
        tbl[7]  = mk(6'b100000, 2'b11, 1, 0);
        tbl[8]  = mk(6'b000000, 2'b11, 1, 0);
        tbl[9]  = mk(6'b001000, 2'b11, 2, 0);
        tbl[10] = mk(6'b000010, 2'b00, 1, 0);
        tbl[11] = mk(6'b000010, 2'b10, 0, 0);
        tbl[12] = mk(6'b100000, 2'b10, 1, 0);
        tbl[13] = mk(6'b000100, 2'b10, 2, 0);
        tbl[14] = mk(6'b000010, 2'b00, 1, 0);
        tbl[15] = mk(6'b000010, 2'b11, 0, 0);
        tbl[16] = mk(6'b100000, 2'b11, 1, 0);
        tbl[17] = mk(6'b000000, 2'b11, 1, 0);
        tbl[18] = mk(6'b001000, 2'b11, 2, 0);
        tbl[19] = mk(6'b000000, 2'b11, 2, 0);
        tbl[20] = mk(6'b010000, 2'b11, 2, 1);
        tbl[21] = mk(6'b000000, 2'b11, 2, 1);
        tbl[22] = mk(6'b100010, 2'b00, 2, 1);
        tbl[23] = mk(6'b000010, 2'b10, 1, 1);
        tbl[24] = mk(6'b000010, 2'b00, 0, 1);
        tbl[25] = mk(6'b000100, 2'b00, 1, 1);
        tbl[26] = mk(6'b000010, 2'b11, 0, 1);
        tbl[27] = mk(6'b101000, 2'b11, 1, 1);
        tbl[28] = mk(6'b000010, 2'b00, 0, 1);
        tbl[29] = mk(6'b100000, 2'b00, 0, 1);
        tbl[30] = mk(6'b000000, 2'b00, 0, 1);

        // Right held through reset: no press until released and pressed again, then equal to dir.
        drive(6'b000100);
        do_reset();
        repeat (5) cycle();
        check("held.cnt", int'(queue_count), 0);
        drive(6'b000000); cycle();
        drive(6'b000100); cycle();
        check("reright.cnt", int'(queue_count), 0);
        drive(6'b000000);
        repeat (100) cycle();
        check("idle.dir", int'(dir), 3);
        check("idle.cnt", int'(queue_count), 0);
        check("idle.drop", int'(drop_cnt), 0);

        for (int i = 0; i < 31; i++) begin
            drive(tbl[i].in);
            cycle();
            check($sformatf("vec%0d.dir", i), int'(dir), int'(tbl[i].dir));
            check($sformatf("vec%0d.cnt", i), int'(queue_count), tbl[i].cnt);
            check($sformatf("vec%0d.drop", i), int'(drop_cnt), tbl[i].drp);
        end

        // game_over flushes, freezes, and keeps tracking button history.
        drive(6'b001000); cycle();
        drive(6'b000010); cycle();
        check("go.pre.dir", int'(dir), 2);
        drive(6'b100000); cycle();
        drive(6'b000100); cycle();
        check("go.pre.cnt", int'(queue_count), 2);
        drive(6'b010011); cycle();
        check("go.flush.cnt", int'(queue_count), 0);
        check("go.flush.dir", int'(dir), 2);
        drive(6'b011011); repeat (3) cycle();
        check("go.hold.dir", int'(dir), 2);
        check("go.hold.cnt", int'(queue_count), 0);
        check("go.hold.drop", int'(drop_cnt), 1);
        drive(6'b011000); cycle();
        check("go.rel.cnt", int'(queue_count), 0);
        drive(6'b000000); cycle();
        drive(6'b010000); cycle();
        check("go.down.cnt", int'(queue_count), 1);
        drive(6'b000010); cycle();
        check("go.down.dir", int'(dir), 1);
        check_model("go.model");

        // Keep the queue full and hammer presses to saturate the drop counter.
        drive(6'b001000); cycle();
        drive(6'b000000); cycle();
        drive(6'b100000); cycle();
        drive(6'b000000); cycle();
        for (int i = 0; i < 130; i++) begin
            drive(6'b001000); cycle();
            drive(6'b000000); cycle();
            drive(6'b000100); cycle();
            drive(6'b000000); cycle();
        end
        check("sat.drop", int'(drop_cnt), 255);
        check("sat.cnt", int'(queue_count), 2);
        drive(6'b000010); cycle();
        check("sat.step.dir", int'(dir), 2);

        // Random run against the model.
        drive(6'b000000);
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            up        = ($urandom_range(0, 3) == 0);
            down      = ($urandom_range(0, 3) == 0);
            left      = ($urandom_range(0, 3) == 0);
            right     = ($urandom_range(0, 3) == 0);
            step      = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 40) == 0) game_over = ~game_over;
            cycle();
            check_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
